// File: rtl/uart_pack_rx.sv
// uart_pack_rx: frames the UART byte stream into header-led packs and presents them as parallel registers.
// Define CHECKSUM_EN to require and verify a trailing XOR checksum byte after the payload.
//
// state     | meaning
// S_IDLE    | hunting for the header byte
// S_PAYLOAD | collecting out pattern, freq pattern and ctrl bytes into the shadow register
// S_CHECK   | waiting for the checksum byte (CHECKSUM_EN builds only)
// S_COMMIT  | shadow has landed on the outputs; o_pack_valid is high for this cycle
module uart_pack_rx #(
   parameter int         DATA_BIT    = 32,
   parameter logic [7:0] HEADER      = 8'hA5,
   parameter int         TIMEOUT_CYC = 20000,
   parameter int         TO_BIT      = 15
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [7:0]          i_data,
   input  logic                i_rx_done_tick,
   output logic [DATA_BIT-1:0] o_out_pattern,
   output logic [DATA_BIT-1:0] o_freq_pattern,
   output logic [7:0]          o_ctrl,
   output logic                o_pack_valid,
   output logic                o_pack_err,
   output logic                o_timeout,
   output logic                o_busy
);

   localparam int PACK_NUM = (DATA_BIT/8)*2+1;
   localparam int IDX_W    = $clog2(PACK_NUM);
   localparam int SH_W     = DATA_BIT*2+8;

`ifdef CHECKSUM_EN
   typedef enum logic [1:0] {S_IDLE, S_PAYLOAD, S_CHECK, S_COMMIT} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_PAYLOAD, S_COMMIT} state_t;
`endif

   state_t            state, state_nxt;
   logic [IDX_W-1:0]  idx, idx_nxt;
   logic [TO_BIT-1:0] timer, timer_nxt;
   logic [7:0]        acc, acc_nxt;
   logic [SH_W-1:0]   shadow, shadow_nxt;
   logic              load_out;
   logic              to_nxt, to_q;
`ifdef CHECKSUM_EN
   logic              err_nxt, err_q;
`endif

   always_comb begin
      state_nxt  = state;
      idx_nxt    = idx;
      timer_nxt  = timer;
      acc_nxt    = acc;
      shadow_nxt = shadow;
      load_out   = 1'b0;
      to_nxt     = 1'b0;
`ifdef CHECKSUM_EN
      err_nxt    = 1'b0;
`endif
      case (state)
         S_PAYLOAD: begin
            if (i_rx_done_tick) begin
               timer_nxt  = '0;
               acc_nxt    = acc ^ i_data;
               // first byte received ends up in the MSB byte of the out pattern
               shadow_nxt = {shadow[SH_W-9:0], i_data};
               if (idx == IDX_W'(PACK_NUM-1)) begin
`ifdef CHECKSUM_EN
                  state_nxt = S_CHECK;
`else
                  state_nxt = S_COMMIT;
                  load_out  = 1'b1;
`endif
               end else begin
                  idx_nxt = idx + IDX_W'(1);
               end
            end else if (timer == TO_BIT'(TIMEOUT_CYC-1)) begin
               state_nxt = S_IDLE;
               to_nxt    = 1'b1;
            end else begin
               timer_nxt = timer + TO_BIT'(1);
            end
         end
`ifdef CHECKSUM_EN
         S_CHECK: begin
            if (i_rx_done_tick) begin
               timer_nxt = '0;
               if (i_data == acc) begin
                  state_nxt = S_COMMIT;
                  load_out  = 1'b1;
               end else begin
                  state_nxt = S_IDLE;
                  err_nxt   = 1'b1;
               end
            end else if (timer == TO_BIT'(TIMEOUT_CYC-1)) begin
               state_nxt = S_IDLE;
               to_nxt    = 1'b1;
            end else begin
               timer_nxt = timer + TO_BIT'(1);
            end
         end
`endif
         default: begin
            // COMMIT hunts exactly like IDLE so a header right after the last byte is not lost
            state_nxt = S_IDLE;
            if (i_rx_done_tick && (i_data == HEADER)) begin
               state_nxt = S_PAYLOAD;
               idx_nxt   = '0;
               acc_nxt   = '0;
               timer_nxt = '0;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= S_IDLE;
         idx            <= '0;
         timer          <= '0;
         acc            <= '0;
         shadow         <= '0;
         to_q           <= 1'b0;
         o_out_pattern  <= '0;
         o_freq_pattern <= '0;
         o_ctrl         <= '0;
      end else begin
         state  <= state_nxt;
         idx    <= idx_nxt;
         timer  <= timer_nxt;
         acc    <= acc_nxt;
         shadow <= shadow_nxt;
         to_q   <= to_nxt;
         if (load_out) begin
            o_out_pattern  <= shadow_nxt[SH_W-1 -: DATA_BIT];
            o_freq_pattern <= shadow_nxt[SH_W-DATA_BIT-1 -: DATA_BIT];
            o_ctrl         <= shadow_nxt[7:0];
         end
      end
   end

`ifdef CHECKSUM_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_nxt;
      end
   end
   assign o_pack_err = err_q;
`else
   assign o_pack_err = 1'b0;
`endif

   assign o_pack_valid = (state == S_COMMIT);
   assign o_timeout    = to_q;
   assign o_busy       = (state != S_IDLE);

endmodule

// File: tb/tb_uart_pack_rx.sv
// Bench for uart_pack_rx: directed and randomized byte streams checked against a frame-level reference model.
// Works with CHECKSUM_EN defined or undefined.
`timescale 1ns/1ps
module tb_uart_pack_rx;
   localparam int         DB  = 32;
   localparam int         NB  = DB/8;
   localparam int         PN  = NB*2+1;
   localparam int         TO  = 40;
   localparam int         TOB = 6;
   localparam logic [7:0] HDR = 8'hA5;
`ifdef CHECKSUM_EN
   localparam bit CK = 1'b1;
`else
   localparam bit CK = 1'b0;
`endif

   // kind: 0 = pack_valid, 1 = pack_err, 2 = timeout
   typedef struct {
      int            kind;
      int            cyc;
      logic [DB-1:0] o;
      logic [DB-1:0] f;
      logic [7:0]    c;
   } ev_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [7:0]    i_data = 8'h00;
   logic          tick = 1'b0;
   logic [DB-1:0] o_out_pattern, o_freq_pattern;
   logic [7:0]    o_ctrl;
   logic          o_pack_valid, o_pack_err, o_timeout, o_busy;

   int            cyc = 0;
   int            n_cmp = 0;
   int            n_err = 0;
   ev_t           act[$];
   ev_t           exp_q[$];
   logic [7:0]    sb[$];
   int            sg[$];
   int            sc[$];
   logic [DB-1:0] m_out = '0;
   logic [DB-1:0] m_freq = '0;
   logic [7:0]    m_ctrl = '0;

   uart_pack_rx #(.DATA_BIT(DB), .HEADER(HDR), .TIMEOUT_CYC(TO), .TO_BIT(TOB)) dut (
      .clk(clk), .rst(rst), .i_data(i_data), .i_rx_done_tick(tick),
      .o_out_pattern(o_out_pattern), .o_freq_pattern(o_freq_pattern), .o_ctrl(o_ctrl),
      .o_pack_valid(o_pack_valid), .o_pack_err(o_pack_err), .o_timeout(o_timeout), .o_busy(o_busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!rst) begin
         if (o_pack_valid) act.push_back('{0, cyc, o_out_pattern, o_freq_pattern, o_ctrl});
         if (o_pack_err)   act.push_back('{1, cyc, o_out_pattern, o_freq_pattern, o_ctrl});
         if (o_timeout)    act.push_back('{2, cyc, o_out_pattern, o_freq_pattern, o_ctrl});
         if (o_pack_valid || o_pack_err || o_timeout) begin
            n_cmp++;
            if ((int'(o_pack_valid) + int'(o_pack_err) + int'(o_timeout)) != 1 || o_busy !== o_pack_valid) begin
               n_err++;
               $display("FAIL strobe_excl cyc=%0d valid=%b err=%b timeout=%b busy=%b required exactly one strobe and busy equal to valid",
                        cyc, o_pack_valid, o_pack_err, o_timeout, o_busy);
            end
         end
      end
   end

   task automatic drive_cycle(input logic t, input logic [7:0] d);
      @(posedge clk);
      #1;
      tick   = t;
      i_data = d;
   endtask

   task automatic drive_stream(input int trail);
      sc.delete();
      foreach (sb[i]) begin
         repeat (sg[i]) drive_cycle(1'b0, 8'h00);
         drive_cycle(1'b1, sb[i]);
         sc.push_back(cyc);
      end
      repeat (trail) drive_cycle(1'b0, 8'h00);
   endtask

   task automatic add_byte(input logic [7:0] b, input int gap);
      sb.push_back(b);
      sg.push_back(gap);
   endtask

   task automatic add_frame(input logic [DB-1:0] o, input logic [DB-1:0] f, input logic [7:0] c,
                            input bit bad, input int gap);
      logic [7:0] pl [PN];
      logic [7:0] ck;
      for (int k = 0; k < NB; k++) begin
         pl[k]    = o[DB-1-8*k -: 8];
         pl[NB+k] = f[DB-1-8*k -: 8];
      end
      pl[PN-1] = c;
      ck = bad ? 8'h07 : 8'h00;
      add_byte(HDR, gap);
      for (int k = 0; k < PN; k++) begin
         add_byte(pl[k], gap);
         ck ^= pl[k];
      end
      if (CK) add_byte(ck, gap);
   endtask

   task automatic model_commit(input logic [7:0] pb [PN], input int s);
      m_out  = '0;
      m_freq = '0;
      for (int k = 0; k < NB; k++) begin
         m_out  = (m_out << 8) | DB'(pb[k]);
         m_freq = (m_freq << 8) | DB'(pb[NB+k]);
      end
      m_ctrl = pb[PN-1];
      exp_q.push_back('{0, s + 1, m_out, m_freq, m_ctrl});
   endtask

   // Frame-level reference: walks the recorded byte arrival cycles and predicts every strobe.
   task automatic build_expected();
      int         st, cnt, last;
      logic [7:0] acc;
      logic [7:0] pb [PN];
      st = 0; cnt = 0; last = 0; acc = '0;
      exp_q.delete();
      foreach (sb[i]) begin
         if (st != 0 && sc[i] - last - 1 >= TO) begin
            exp_q.push_back('{2, last + TO + 1, m_out, m_freq, m_ctrl});
            st = 0;
         end
         if (st == 0) begin
            if (sb[i] == HDR) begin
               st = 1; cnt = 0; acc = '0;
            end
         end else if (st == 1) begin
            pb[cnt] = sb[i];
            acc ^= sb[i];
            cnt++;
            if (cnt == PN) begin
               st = CK ? 2 : 0;
               if (!CK) model_commit(pb, sc[i]);
            end
         end else begin
            if (sb[i] == acc) model_commit(pb, sc[i]);
            else exp_q.push_back('{1, sc[i] + 1, m_out, m_freq, m_ctrl});
            st = 0;
         end
         last = sc[i];
      end
      if (st != 0) exp_q.push_back('{2, last + TO + 1, m_out, m_freq, m_ctrl});
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) drive_cycle(1'b0, 8'h00);
      n_cmp++;
      if (o_out_pattern !== '0 || o_freq_pattern !== '0 || o_ctrl !== 8'h00 || o_pack_valid !== 1'b0 ||
          o_pack_err !== 1'b0 || o_timeout !== 1'b0 || o_busy !== 1'b0) begin
         n_err++;
         $display("FAIL reset_values out=%h freq=%h ctrl=%h valid=%b err=%b to=%b busy=%b required all zero",
                  o_out_pattern, o_freq_pattern, o_ctrl, o_pack_valid, o_pack_err, o_timeout, o_busy);
      end
      rst = 1'b0;
      m_out = '0; m_freq = '0; m_ctrl = '0;
   endtask

   task automatic test_frames();
      logic [7:0] g [3] = '{8'h00, 8'hFF, 8'h5A};
      int         n0;
      int         li;
      for (int k = 0; k < 3; k++) begin
         drive_cycle(1'b1, g[k]);
         drive_cycle(1'b0, 8'h00);
         n_cmp++;
         if (o_busy !== 1'b0) begin
            n_err++;
            $display("FAIL garbage_busy byte=%h busy=%b required 0", g[k], o_busy);
         end
      end
      act.delete(); sb.delete(); sg.delete();
      add_frame(32'h12345678, 32'h0000FFFF, 8'h03, 1'b0, 0);
      add_frame(32'h12345678, 32'h0000FFFF, 8'h03, 1'b1, 2);
      for (int k = 0; k < 3; k++) add_byte(g[k], 1);
      add_frame(32'hDEADBEEF, 32'h01020304, 8'h7E, 1'b0, 1);
      add_byte(HDR, 0);
      for (int k = 0; k < 4; k++) add_byte(8'h11 * (k + 1), 0);
      n0 = sb.size();
      add_frame(32'hCAFEF00D, 32'h0BADC0DE, 8'h5C, 1'b0, 0);
      sg[n0] = TO + 3;
      add_frame(32'h01234567, 32'h89ABCDEF, 8'h11, 1'b0, 0);
      add_frame(32'hFEDCBA98, 32'h76543210, 8'h22, 1'b0, 0);
      n0 = sb.size();
      add_frame(32'h0F1E2D3C, 32'h4B5A6978, 8'h33, 1'b0, 1);
      sg[n0 + 3] = TO - 1;
      n0 = sb.size();
      add_frame(32'h10203040, 32'h50607080, 8'h90, 1'b0, 1);
      sg[n0 + 3] = TO;
      add_frame(32'hA5A5A5A5, 32'h00A500A5, 8'hA5, 1'b0, 0);
      drive_stream(TO + 5);
      build_expected();
      n_cmp++;
      if (act.size() != exp_q.size()) begin
         n_err++;
         $display("FAIL frames_count events=%0d required=%0d", act.size(), exp_q.size());
      end
      for (int i = 0; i < act.size() && i < exp_q.size(); i++) begin
         n_cmp++;
         if (act[i].kind != exp_q[i].kind || act[i].cyc != exp_q[i].cyc || act[i].o !== exp_q[i].o ||
             act[i].f !== exp_q[i].f || act[i].c !== exp_q[i].c) begin
            n_err++;
            $display("FAIL frames_ev%0d got kind=%0d cyc=%0d out=%h freq=%h ctrl=%h required kind=%0d cyc=%0d out=%h freq=%h ctrl=%h",
                     i, act[i].kind, act[i].cyc, act[i].o, act[i].f, act[i].c,
                     exp_q[i].kind, exp_q[i].cyc, exp_q[i].o, exp_q[i].f, exp_q[i].c);
         end
      end
      li = PN + int'(CK);
      n_cmp++;
      if (act.size() == 0) begin
         n_err++;
         $display("FAIL first_pack no event seen required valid 12345678/0000ffff/03");
      end else if (act[0].kind != 0 || act[0].o !== 32'h12345678 || act[0].f !== 32'h0000FFFF ||
                   act[0].c !== 8'h03 || act[0].cyc != sc[li] + 1) begin
         n_err++;
         $display("FAIL first_pack got kind=%0d cyc=%0d out=%h freq=%h ctrl=%h required kind=0 cyc=%0d out=12345678 freq=0000ffff ctrl=03",
                  act[0].kind, act[0].cyc, act[0].o, act[0].f, act[0].c, sc[li] + 1);
      end
   endtask

   task automatic test_random();
      int n0, r;
      act.delete(); sb.delete(); sg.delete();
      for (int n = 0; n < 40; n++) begin
         r = $urandom_range(0, 9);
         if (r == 0) begin
            for (int k = 0; k < 3; k++) begin
               logic [7:0] b;
               b = 8'($urandom);
               if (b == HDR) b = 8'h00;
               add_byte(b, $urandom_range(0, 3));
            end
         end
         n0 = sb.size();
         add_frame((r == 3) ? {NB{HDR}} : DB'($urandom), DB'($urandom), 8'($urandom),
                   ($urandom_range(0, 4) == 0), $urandom_range(0, 2));
         if (r == 1) sg[n0 + $urandom_range(1, PN)] = TO - 1;
         if (r == 2) sg[n0 + $urandom_range(1, PN)] = TO + $urandom_range(0, 2);
      end
      drive_stream(TO + 5);
      build_expected();
      n_cmp++;
      if (act.size() != exp_q.size()) begin
         n_err++;
         $display("FAIL random_count events=%0d required=%0d", act.size(), exp_q.size());
      end
      for (int i = 0; i < act.size() && i < exp_q.size(); i++) begin
         n_cmp++;
         if (act[i].kind != exp_q[i].kind || act[i].cyc != exp_q[i].cyc || act[i].o !== exp_q[i].o ||
             act[i].f !== exp_q[i].f || act[i].c !== exp_q[i].c) begin
            n_err++;
            $display("FAIL random_ev%0d got kind=%0d cyc=%0d out=%h freq=%h ctrl=%h required kind=%0d cyc=%0d out=%h freq=%h ctrl=%h",
                     i, act[i].kind, act[i].cyc, act[i].o, act[i].f, act[i].c,
                     exp_q[i].kind, exp_q[i].cyc, exp_q[i].o, exp_q[i].f, exp_q[i].c);
         end
      end
   endtask

   task automatic test_reset_mid();
      int li;
      act.delete(); sb.delete(); sg.delete();
      add_byte(HDR, 1);
      for (int k = 0; k < 6; k++) add_byte(8'h40 + 8'(k), 0);
      drive_stream(0);
      rst = 1'b1;
      drive_cycle(1'b0, 8'h00);
      rst = 1'b0;
      n_cmp++;
      if (o_busy !== 1'b0 || o_out_pattern !== '0 || o_freq_pattern !== '0 || o_ctrl !== 8'h00) begin
         n_err++;
         $display("FAIL rst_mid_state busy=%b out=%h freq=%h ctrl=%h required all zero",
                  o_busy, o_out_pattern, o_freq_pattern, o_ctrl);
      end
      repeat (TO + 5) drive_cycle(1'b0, 8'h00);
      n_cmp++;
      if (act.size() != 0) begin
         n_err++;
         $display("FAIL rst_mid_silent events=%0d required 0", act.size());
      end
      m_out = '0; m_freq = '0; m_ctrl = '0;
      act.delete(); sb.delete(); sg.delete();
      add_frame(32'h55AA33CC, 32'h87654321, 8'hE1, 1'b0, 0);
      drive_stream(TO + 5);
      li = PN + int'(CK);
      n_cmp++;
      if (act.size() != 1) begin
         n_err++;
         $display("FAIL rst_mid_count events=%0d required 1", act.size());
      end else if (act[0].kind != 0 || act[0].cyc != sc[li] + 1 || act[0].o !== 32'h55AA33CC ||
                   act[0].f !== 32'h87654321 || act[0].c !== 8'hE1) begin
         n_err++;
         $display("FAIL rst_mid_pack got kind=%0d cyc=%0d out=%h freq=%h ctrl=%h required kind=0 cyc=%0d out=55aa33cc freq=87654321 ctrl=e1",
                  act[0].kind, act[0].cyc, act[0].o, act[0].f, act[0].c, sc[li] + 1);
      end
      m_out = 32'h55AA33CC; m_freq = 32'h87654321; m_ctrl = 8'hE1;
   endtask

   initial begin
      test_reset();
      test_frames();
      test_random();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
